osc_pulse: RTL and testbench

Parametrised pulse/square oscillator for the synth voice path, generalising the fixed-width square oscillator: programmable period in clock cycles, programmable duty cycle, programmable amplitude, and a signed output. Period, duty, mode and amplitude are shadowed and applied only at period boundaries, so updates never glitch the waveform. A one-cycle `phase_start` pulse marks each period start and is used to hard-sync other oscillators and envelopes.

---
 rtl/osc_pulse.sv | 119 +++++++++++
 tb/tb_osc_pulse.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/osc_pulse.sv
// Pulse/square oscillator with signed amplitude output; period, high-phase length
// and amplitude are shadowed and only take effect at period boundaries.
module osc_pulse #(
  parameter int unsigned SIG_W    = 16,
  parameter int unsigned PERIOD_W = 20,
  parameter int unsigned DUTY_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUTY_W-1:0]   duty,
  input  logic [SIG_W-2:0]    amp,
  output logic [SIG_W-1:0]    sig,
  output logic                phase_start,
  output logic                active
);

  localparam int unsigned PROD_W = PERIOD_W + DUTY_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] high_q, high_d;
  logic [SIG_W-2:0]    amp_q, amp_d;
  logic [SIG_W-1:0]    sig_d;
  logic                ps_d;

  logic                valid_c;
  logic                load_c;
  logic [PROD_W-1:0]   prod_c;
  logic [PERIOD_W-1:0] high_c;
  logic [PERIOD_W-1:0] cnt_inc_c;

  function automatic logic [SIG_W-1:0] pos_lvl(input logic [SIG_W-2:0] a);
    return {1'b0, a};
  endfunction

  function automatic logic [SIG_W-1:0] neg_lvl(input logic [SIG_W-2:0] a);
    return SIG_W'(0) - {1'b0, a};
  endfunction

  // High-phase length from the live inputs; product kept full width, then truncated
  assign valid_c   = en && ((mode == 2'b01) || (mode == 2'b10)) && (period >= PERIOD_W'(2));
  assign prod_c    = PROD_W'(period) * PROD_W'(duty);
  assign high_c    = (mode == 2'b10) ? prod_c[PROD_W-1:DUTY_W] : (period >> 1);
  assign cnt_inc_c = cnt_q + PERIOD_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    high_d   = high_q;
    amp_d    = amp_q;
    sig_d    = sig;
    ps_d     = 1'b0;
    load_c   = 1'b0;

    if (state_q == IDLE) begin
      if (valid_c) load_c = 1'b1;
      else         sig_d  = '0;
    end else begin
      if (!en) begin
        state_d = IDLE;
        cnt_d   = '0;
        sig_d   = '0;
      end else if (cnt_q == (period_q - PERIOD_W'(1))) begin
        if (valid_c) begin
          load_c = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          sig_d   = '0;
        end
      end else begin
        cnt_d = cnt_inc_c;
        sig_d = (cnt_inc_c < high_q) ? pos_lvl(amp_q) : neg_lvl(amp_q);
      end
    end

    // Period boundary: capture the shadows and start a fresh period
    if (load_c) begin
      state_d  = RUN;
      cnt_d    = '0;
      period_d = period;
      high_d   = high_c;
      amp_d    = amp;
      sig_d    = (high_c != '0) ? pos_lvl(amp) : neg_lvl(amp);
      ps_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      high_q      <= '0;
      amp_q       <= '0;
      sig         <= '0;
      phase_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      high_q      <= high_d;
      amp_q       <= amp_d;
      sig         <= sig_d;
      phase_start <= ps_d;
    end
  end

  assign active = (state_q == RUN);

endmodule

// File: tb/tb_osc_pulse.sv
// Self-checking bench for osc_pulse: fixed vector table, corner-case sequences and
// randomized stimulus against a position-in-period waveform model.
module tb_osc_pulse;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [19:0] period;
  logic [7:0]  duty;
  logic [14:0] amp;
  logic [15:0] sig;
  logic        phase_start;
  logic        active;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  osc_pulse dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .period      (period),
    .duty        (duty),
    .amp         (amp),
    .sig         (sig),
    .phase_start (phase_start),
    .active      (active)
  );

  // Reference model: whether a period is in progress, position within it, and latched config
  bit          m_run;
  int          m_pos, m_p, m_h, m_a;
  logic [15:0] m_sig;
  bit          m_ps;

  function automatic logic [15:0] lvl(input int a, input bit hi);
    return hi ? 16'(a) : 16'(-a);
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_sig = '0; m_ps = 0;
  endtask

  task automatic model_edge();
    bit v;
    v = en && (mode == 2'd1 || mode == 2'd2) && (period >= 20'd2);
    if (m_run && !en) begin
      m_run = 0; m_sig = '0; m_ps = 0;
    end else if (m_run && m_pos != m_p - 1) begin
      m_pos++;
      m_sig = lvl(m_a, m_pos < m_h);
      m_ps  = 0;
    end else if (v) begin
      m_p   = int'(period);
      m_h   = (mode == 2'd1) ? m_p / 2 : int'((longint'(m_p) * longint'(duty)) / 256);
      m_a   = int'(amp);
      m_pos = 0;
      m_run = 1;
      m_sig = lvl(m_a, m_h > 0);
      m_ps  = 1;
    end else begin
      m_run = 0; m_sig = '0; m_ps = 0;
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("sig", 32'(sig), 32'(m_sig));
    chk("phase_start", 32'(phase_start), 32'(m_ps));
    chk("active", 32'(active), 32'(m_run));
  endtask

  task automatic drive(input bit e, input int md, input int p, input int d, input int a);
    en = e; mode = 2'(md); period = 20'(p); duty = 8'(d); amp = 15'(a);
  endtask

  typedef struct {
    bit          en;
    int          mode;
    int          period;
    int          duty;
    int          amp;
    logic [15:0] sig;
    bit          ps;
    bit          act;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit e, input int md, input int p, input int d,
                              input int a, input logic [15:0] s, input bit ps, input bit ac);
    vec_t r;
    r.en = e; r.mode = md; r.period = p; r.duty = d; r.amp = a;
    r.sig = s; r.ps = ps; r.act = ac;
    tbl.push_back(r);
  endfunction

  initial begin
    int pos_n, neg_n, ps_n;

    // Fixed vectors: idle, invalid period, square 10, mode 11 mid-run, square 7
    add(0, 1, 10, 0, 'h0FFF, 16'h0000, 0, 0);
    add(1, 1, 1,  0, 'h0FFF, 16'h0000, 0, 0);
    add(1, 1, 10, 0, 'h0FFF, 16'h0FFF, 1, 1);
    for (int i = 1; i < 5;  i++) add(1, 1, 10, 0, 'h0FFF, 16'h0FFF, 0, 1);
    for (int i = 5; i < 10; i++) add(1, 1, 10, 0, 'h0FFF, 16'hF001, 0, 1);
    add(1, 1, 10, 0, 'h0FFF, 16'h0FFF, 1, 1);
    for (int i = 1; i < 5;  i++) add(1, 3, 10, 0, 'h0FFF, 16'h0FFF, 0, 1);
    for (int i = 5; i < 10; i++) add(1, 3, 10, 0, 'h0FFF, 16'hF001, 0, 1);
    add(1, 3, 10, 0, 'h0FFF, 16'h0000, 0, 0);
    add(1, 3, 10, 0, 'h0FFF, 16'h0000, 0, 0);
    add(1, 1, 7,  0, 'h0100, 16'h0100, 1, 1);
    for (int i = 1; i < 3; i++) add(1, 1, 7, 0, 'h0100, 16'h0100, 0, 1);
    for (int i = 3; i < 7; i++) add(1, 1, 7, 0, 'h0100, 16'hFF00, 0, 1);
    add(1, 1, 7,  0, 'h0100, 16'h0100, 1, 1);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_sig", 32'(sig), 32'h0);
    chk("reset_ps", 32'(phase_start), 32'h0);
    chk("reset_active", 32'(active), 32'h0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].mode, tbl[i].period, tbl[i].duty, tbl[i].amp);
      tick();
      chk($sformatf("tbl%0d_sig", i), 32'(sig), 32'(tbl[i].sig));
      chk($sformatf("tbl%0d_ps", i), 32'(phase_start), 32'(tbl[i].ps));
      chk($sformatf("tbl%0d_active", i), 32'(active), 32'(tbl[i].act));
    end

    // Pulse 100 cycles at duty 64/256: 25 high cycles, one start
    drive(0, 2, 100, 64, 'h1234); tick();
    en = 1'b1;
    pos_n = 0; ps_n = 0;
    repeat (100) begin
      tick();
      if (sig == 16'h1234) pos_n++;
      if (phase_start) ps_n++;
    end
    chk("pulse_high_cycles", 32'(pos_n), 32'd25);
    chk("pulse_starts", 32'(ps_n), 32'd1);

    // Duty 0: whole period low, starts still pulse
    drive(0, 2, 10, 0, 'h0FFF); tick();
    en = 1'b1;
    neg_n = 0; ps_n = 0;
    repeat (20) begin
      tick();
      if (sig == 16'hF001) neg_n++;
      if (phase_start) ps_n++;
    end
    chk("duty0_low_cycles", 32'(neg_n), 32'd20);
    chk("duty0_starts", 32'(ps_n), 32'd2);

    // Period change at cycle 3 is deferred to the boundary
    drive(0, 1, 10, 0, 'h0800); tick();
    en = 1'b1;
    repeat (3) tick();
    period = 20'd20;
    pos_n = 0;
    repeat (7) begin tick(); if (sig == 16'h0800) pos_n++; end
    chk("glitch_old_high", 32'(pos_n), 32'd2);
    pos_n = 0; ps_n = 0;
    repeat (20) begin
      tick();
      if (sig == 16'h0800) pos_n++;
      if (phase_start) ps_n++;
    end
    chk("glitch_new_high", 32'(pos_n), 32'd10);
    chk("glitch_new_starts", 32'(ps_n), 32'd1);

    // Enable drop in the high phase, then restart
    drive(0, 1, 10, 0, 'h0800); tick();
    en = 1'b1;
    repeat (2) tick();
    en = 1'b0;
    tick();
    chk("endrop_sig", 32'(sig), 32'h0);
    chk("endrop_active", 32'(active), 32'h0);
    en = 1'b1;
    tick();
    chk("enrise_ps", 32'(phase_start), 32'h1);
    chk("enrise_sig", 32'(sig), 32'h0800);

    // Asynchronous reset between edges
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sig", 32'(sig), 32'h0);
    chk("async_rst_ps", 32'(phase_start), 32'h0);
    chk("async_rst_active", 32'(active), 32'h0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ps", 32'(phase_start), 32'h1);
    chk("post_rst_sig", 32'(sig), 32'h0800);

    // Randomized stimulus against the model
    repeat (4000) begin
      if ($urandom % 16 == 0) en = ($urandom % 8) != 0;
      if ($urandom % 12 == 0) mode = 2'($urandom % 4);
      if ($urandom % 10 == 0) period = 20'($urandom_range(0, 14));
      if ($urandom % 10 == 0) duty = 8'($urandom);
      if ($urandom % 10 == 0) amp = 15'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
